// File: rtl/xbar_cfg_pkg.sv
// -----------------------------------------------------------------------------
// xbar_cfg_pkg
// Shared parameters, state encoding and the selector range check used by the
// crossbar configuration loader (xbar_cfg_loader).
// -----------------------------------------------------------------------------
package xbar_cfg_pkg;

    localparam int NUM_IN    = 35;                            // crossbar inputs
    localparam int NUM_OUT   = 48;                            // crossbar outputs
    localparam int SEL_W     = 6;                             // bits per selector
    localparam int WORD_W    = 32;                            // config word width
    localparam int CFG_W     = NUM_OUT * SEL_W;               // 288
    localparam int NUM_WORDS = (CFG_W + WORD_W - 1) / WORD_W; // 9
    // Shadow is a whole number of words; bits above CFG_W are never committed.
    localparam int SHD_W     = NUM_WORDS * WORD_W;
    localparam int WIDX_W    = $clog2(NUM_WORDS);
    localparam int SIDX_W    = $clog2(NUM_OUT);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK,
        COMMIT
    } cfg_state_t;

    // Extract selector i from the shadow vector and report whether it names
    // an existing crossbar input. Compared one bit wider so NUM_IN == 2**SEL_W
    // would still work.
    function automatic logic sel_legal(input logic [SHD_W-1:0]  shadow,
                                       input logic [SIDX_W-1:0] i);
        logic [SEL_W-1:0] sel;
        sel = shadow[int'(i)*SEL_W +: SEL_W];
        return ({1'b0, sel} < (SEL_W+1)'(NUM_IN));
    endfunction

endpackage

// File: rtl/xbar_cfg_loader.sv
// -----------------------------------------------------------------------------
// xbar_cfg_loader
// Writer side of the crossbar configuration interface. Collects NUM_WORDS
// configuration words (LSB-first) into a shadow vector, range-checks one
// selector per cycle, then commits the whole vector atomically to
// io_mux_configs. Framing or range failures raise a sticky io_cfg_error and
// leave the active configuration untouched.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous reset, active low
//   io_cfg_valid   in   word valid
//   io_cfg_ready   out  loader accepts a word (IDLE/LOAD only)
//   io_cfg_data    in   WORD_W configuration word
//   io_cfg_last    in   final word of a load
//   io_mux_configs out  CFG_W active packed selectors
//   io_cfg_done    out  one-cycle pulse on commit
//   io_cfg_error   out  sticky error, cleared by the next word-0 transfer
//   io_busy        out  high while checking/committing
// Optional (macro XBAR_CFG_READBACK_EN):
//   io_rd_idx      in   4-bit word index into the active configuration
//   io_rd_data     out  WORD_W combinational readback, 0 for idx >= NUM_WORDS
// -----------------------------------------------------------------------------
module xbar_cfg_loader
    import xbar_cfg_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              io_cfg_valid,
    output logic              io_cfg_ready,
    input  logic [WORD_W-1:0] io_cfg_data,
    input  logic              io_cfg_last,
    output logic [CFG_W-1:0]  io_mux_configs,
    output logic              io_cfg_done,
    output logic              io_cfg_error,
    output logic              io_busy
`ifdef XBAR_CFG_READBACK_EN
    ,
    input  logic [3:0]        io_rd_idx,
    output logic [WORD_W-1:0] io_rd_data
`endif
);

    cfg_state_t        state_q,  state_d;
    logic [SHD_W-1:0]  shadow_q, shadow_d;
    logic [WIDX_W-1:0] widx_q,   widx_d;
    logic [SIDX_W-1:0] sidx_q,   sidx_d;
    logic [CFG_W-1:0]  mux_q,    mux_d;
    logic              done_q,   done_d;
    logic              error_q,  error_d;
    // Holds ready low while reset is asserted and until the first clock after.
    logic              live_q;

    logic              xfer;
    logic [WIDX_W-1:0] cur_idx;
    logic              is_final;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            widx_q   <= '0;
            sidx_q   <= '0;
            mux_q    <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            live_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            widx_q   <= widx_d;
            sidx_q   <= sidx_d;
            mux_q    <= mux_d;
            done_q   <= done_d;
            error_q  <= error_d;
            live_q   <= 1'b1;
        end
    end

    assign io_cfg_ready   = live_q && ((state_q == IDLE) || (state_q == LOAD));
    assign io_busy        = (state_q == CHECK) || (state_q == COMMIT);
    assign io_mux_configs = mux_q;
    assign io_cfg_done    = done_q;
    assign io_cfg_error   = error_q;

    assign xfer     = io_cfg_valid && io_cfg_ready;
    // A transfer in IDLE is always word 0, whatever the stale index says.
    assign cur_idx  = (state_q == IDLE) ? '0 : widx_q;
    assign is_final = (cur_idx == WIDX_W'(NUM_WORDS - 1));

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        widx_d   = widx_q;
        sidx_d   = sidx_q;
        mux_d    = mux_q;
        done_d   = 1'b0;
        error_d  = error_q;

        case (state_q)
            IDLE, LOAD: begin
                if (xfer) begin
                    shadow_d[int'(cur_idx)*WORD_W +: WORD_W] = io_cfg_data;
                    if (state_q == IDLE) begin
                        error_d = 1'b0;
                    end
                    if (io_cfg_last != is_final) begin
                        // Framing error: drop the partial load.
                        error_d  = 1'b1;
                        shadow_d = '0;
                        widx_d   = '0;
                        state_d  = IDLE;
                    end else if (is_final) begin
                        widx_d  = '0;
                        sidx_d  = '0;
                        state_d = CHECK;
                    end else begin
                        widx_d  = cur_idx + WIDX_W'(1);
                        state_d = LOAD;
                    end
                end
            end
            CHECK: begin
                if (!sel_legal(shadow_q, sidx_q)) begin
                    error_d  = 1'b1;
                    shadow_d = '0;
                    sidx_d   = '0;
                    state_d  = IDLE;
                end else if (sidx_q == SIDX_W'(NUM_OUT - 1)) begin
                    state_d = COMMIT;
                end else begin
                    sidx_d = sidx_q + SIDX_W'(1);
                end
            end
            COMMIT: begin
                mux_d   = shadow_q[CFG_W-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef XBAR_CFG_READBACK_EN
    logic [SHD_W-1:0] cfg_pad;

    always_comb begin
        cfg_pad             = '0;
        cfg_pad[CFG_W-1:0]  = mux_q;
        io_rd_data          = '0;
        if (io_rd_idx < 4'(NUM_WORDS)) begin
            io_rd_data = cfg_pad[int'(io_rd_idx)*WORD_W +: WORD_W];
        end
    end
`endif

endmodule
